// File: rtl/accel_seq_fsm.sv
// accel_seq_fsm
//   Control sequencer for a single crypto accelerator. Dequeues one
//   instruction, issues NUM_SRC memory-to-accelerator reads, the accelerator
//   operation command and one accelerator-to-memory write over the shared
//   bus. Each bus phase waits for its ACK with a timeout. The result is then
//   posted to the completion queue as {err, dest}.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   req_valid       request queue holds an instruction
//   req_data        {mode, src[NUM_SRC-1] .. src[0], dest}
//   ready_req_out   sequencer is idle and dequeues on req_valid
//   arb_req         bus request to the arbiter
//   arb_grant       arbiter grant
//   ack_in          {valid, id[1:0]} completion ACK from memory/accelerator
//   data_out        bus command word {field, 2'b00, dst_id, src_id, opcode}
//   compq_data_out  completion entry {err, dest}
//   valid_compq_out completion entry valid
//   comq_ready_in   completion queue can accept
module accel_seq_fsm #(
  parameter int         ADDRW     = 24,
  parameter logic [1:0] ACCEL_ID  = 2'b01,
  parameter logic [1:0] MEM_ID    = 2'b00,
  parameter int         NUM_SRC   = 2,
  parameter int         TIMEOUT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic [(NUM_SRC+1)*ADDRW:0]   req_data,
  output logic                         ready_req_out,
  output logic                         arb_req,
  input  logic                         arb_grant,
  input  logic [2:0]                   ack_in,
  output logic [ADDRW+7:0]             data_out,
  output logic [ADDRW:0]               compq_data_out,
  output logic                         valid_compq_out,
  input  logic                         comq_ready_in
);

  localparam int REQ_W = (NUM_SRC+1)*ADDRW+1;
  localparam int CMD_W = ADDRW+8;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_REQ   = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] OP_REQ   = 3'd3;
  localparam logic [2:0] OP_WAIT  = 3'd4;
  localparam logic [2:0] WR_REQ   = 3'd5;
  localparam logic [2:0] WR_WAIT  = 3'd6;
  localparam logic [2:0] COMPLETE = 3'd7;

  localparam logic [1:0]           LAST_SRC = 2'(NUM_SRC-1);
  localparam logic [TIMEOUT_W-1:0] TMO_MAX  = '1;

  logic [2:0]           state;
  logic [1:0]           src_idx;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 err;
  logic [REQ_W-1:0]     req_q;
  logic [ADDRW-1:0]     src_arr [4];
  logic                 ack_mem;
  logic                 ack_acc;
  logic                 tmo_hit;

  function automatic logic [CMD_W-1:0] rd_cmd(input logic [ADDRW-1:0] src);
    return {src, 2'b00, ACCEL_ID, MEM_ID, 2'b01};
  endfunction

  function automatic logic [CMD_W-1:0] op_cmd(input logic mode);
    return {{ADDRW{1'b0}}, mode, 1'b0, ACCEL_ID, 4'b0011};
  endfunction

  function automatic logic [CMD_W-1:0] wr_cmd(input logic [ADDRW-1:0] dest);
    return {dest, 2'b00, MEM_ID, ACCEL_ID, 2'b10};
  endfunction

  // Source table padded to four entries so a 2-bit src_idx indexes it cleanly
  // for every legal NUM_SRC.
  for (genvar i = 0; i < 4; i++) begin : g_src
    if (i < NUM_SRC) begin : g_used
      assign src_arr[i] = req_q[ADDRW*(i+1) +: ADDRW];
    end else begin : g_unused
      assign src_arr[i] = '0;
    end
  end

  assign ack_mem = (ack_in == {1'b1, MEM_ID});
  assign ack_acc = (ack_in == {1'b1, ACCEL_ID});
  assign tmo_hit = (tmo_cnt == TMO_MAX);

  // Sequencing state; a matching ACK takes priority over the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      src_idx <= '0;
      tmo_cnt <= '0;
      err     <= 1'b0;
      req_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q   <= req_data;
            src_idx <= '0;
            err     <= 1'b0;
            state   <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (arb_grant) begin
            tmo_cnt <= '0;
            state   <= RD_WAIT;
          end
        end
        OP_REQ: begin
          if (arb_grant) begin
            tmo_cnt <= '0;
            state   <= OP_WAIT;
          end
        end
        WR_REQ: begin
          if (arb_grant) begin
            tmo_cnt <= '0;
            state   <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (ack_mem) begin
            if (src_idx < LAST_SRC) begin
              src_idx <= src_idx + 2'd1;
              state   <= RD_REQ;
            end else begin
              state <= OP_REQ;
            end
          end else if (tmo_hit) begin
            err   <= 1'b1;
            state <= COMPLETE;
          end else begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
          end
        end
        OP_WAIT: begin
          if (ack_acc) begin
            state <= WR_REQ;
          end else if (tmo_hit) begin
            err   <= 1'b1;
            state <= COMPLETE;
          end else begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
          end
        end
        WR_WAIT: begin
          if (ack_mem) begin
            state <= COMPLETE;
          end else if (tmo_hit) begin
            err   <= 1'b1;
            state <= COMPLETE;
          end else begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
          end
        end
        COMPLETE: begin
          if (comq_ready_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state only, so an asynchronous reset drops them at once.
  always_comb begin
    ready_req_out   = 1'b0;
    arb_req         = 1'b0;
    data_out        = '0;
    valid_compq_out = 1'b0;
    compq_data_out  = '0;
    case (state)
      IDLE: ready_req_out = 1'b1;
      RD_REQ: begin
        arb_req  = 1'b1;
        data_out = rd_cmd(src_arr[src_idx]);
      end
      RD_WAIT: data_out = rd_cmd(src_arr[src_idx]);
      OP_REQ: begin
        arb_req  = 1'b1;
        data_out = op_cmd(req_q[REQ_W-1]);
      end
      OP_WAIT: data_out = op_cmd(req_q[REQ_W-1]);
      WR_REQ: begin
        arb_req  = 1'b1;
        data_out = wr_cmd(req_q[ADDRW-1:0]);
      end
      WR_WAIT: data_out = wr_cmd(req_q[ADDRW-1:0]);
      COMPLETE: begin
        valid_compq_out = 1'b1;
        compq_data_out  = {err, req_q[ADDRW-1:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_accel_seq_fsm.sv
// tb_accel_seq_fsm
//   Self-checking bench for accel_seq_fsm (NUM_SRC=2, TIMEOUT_W=4): a table of
//   cycle vectors for the basic transaction, hand-written corner sequences,
//   then randomized traffic compared against a transaction-level model.
module tb_accel_seq_fsm;

  localparam int         ADDRW   = 24;
  localparam int         NUM_SRC = 2;
  localparam int         TW      = 4;
  localparam logic [1:0] ACC     = 2'b01;
  localparam logic [1:0] MEM     = 2'b00;
  localparam int         DW      = ADDRW + 8;
  localparam int         CW      = ADDRW + 1;
  localparam int         RW      = (NUM_SRC + 1) * ADDRW + 1;
  localparam int         TMO_LIM = 2**TW - 1;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic [RW-1:0] req_data;
  logic          ready_req_out;
  logic          arb_req;
  logic          arb_grant;
  logic [2:0]    ack_in;
  logic [DW-1:0] data_out;
  logic [CW-1:0] compq_data_out;
  logic          valid_compq_out;
  logic          comq_ready_in;

  accel_seq_fsm #(
    .ADDRW(ADDRW), .ACCEL_ID(ACC), .MEM_ID(MEM), .NUM_SRC(NUM_SRC), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .ready_req_out(ready_req_out), .arb_req(arb_req), .arb_grant(arb_grant),
    .ack_in(ack_in), .data_out(data_out), .compq_data_out(compq_data_out),
    .valid_compq_out(valid_compq_out), .comq_ready_in(comq_ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int hs_cnt;

  always @(posedge clk) begin
    if (rst) hs_cnt <= 0;
    else if (req_valid && ready_req_out) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Instruction = list of NUM_SRC+2 bus phases; each phase is requested, then
  // waited on. m_phase walks the list; m_done marks a posted completion.
  bit            m_busy, m_done, m_wait, m_err;
  int            m_phase, m_cnt;
  logic [RW-1:0] m_req;

  function automatic logic [1:0] exp_id(input int ph);
    return (ph == NUM_SRC) ? ACC : MEM;
  endfunction

  function automatic logic [DW-1:0] cmd_of(input int ph, input logic [RW-1:0] rq);
    logic [ADDRW-1:0] a;
    if (ph < NUM_SRC) begin
      a = ADDRW'(rq >> (ADDRW * (ph + 1)));
      return {a, 2'b00, ACC, MEM, 2'b01};
    end
    if (ph == NUM_SRC) return {{ADDRW{1'b0}}, rq[RW-1], 1'b0, ACC, 4'b0011};
    return {rq[ADDRW-1:0], 2'b00, MEM, ACC, 2'b10};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_wait = 0; m_err = 0; m_phase = 0; m_cnt = 0; m_req = '0;
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1; m_done = 0; m_wait = 0; m_err = 0; m_phase = 0; m_req = req_data;
      end
    end else if (m_done) begin
      if (comq_ready_in) m_busy = 0;
    end else if (!m_wait) begin
      if (arb_grant) begin m_wait = 1; m_cnt = 0; end
    end else begin
      if (ack_in == {1'b1, exp_id(m_phase)}) begin
        m_wait = 0;
        m_phase++;
        if (m_phase == NUM_SRC + 2) m_done = 1;
      end else if (m_cnt == TMO_LIM) begin
        m_err = 1; m_done = 1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_model();
    logic          e_rdy, e_arb, e_vld;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_cq;
    e_rdy  = !m_busy;
    e_arb  = m_busy && !m_done && !m_wait;
    e_vld  = m_busy && m_done;
    e_data = (m_busy && !m_done) ? cmd_of(m_phase, m_req) : '0;
    e_cq   = e_vld ? {m_err, m_req[ADDRW-1:0]} : '0;
    chk("model_ready", 64'(ready_req_out), 64'(e_rdy));
    chk("model_arb_req", 64'(arb_req), 64'(e_arb));
    chk("model_data_out", 64'(data_out), 64'(e_data));
    chk("model_valid_compq", 64'(valid_compq_out), 64'(e_vld));
    chk("model_compq_data", 64'(compq_data_out), 64'(e_cq));
  endtask

  // Inputs are set at the falling edge; the model consumes them, then the DUT
  // sees them at the rising edge and outputs are sampled at the next fall.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit at_stop(input int sp);
    if (sp < 0) return m_busy && m_done;
    return m_busy && !m_done && m_wait && (m_phase == sp);
  endfunction

  // Zero-wait grants and immediate matching ACKs until the model reaches the
  // WAIT of phase stop_phase (or the completion when stop_phase < 0).
  task automatic advance(input int stop_phase, input int budget);
    int n;
    bit hit;
    n = 0;
    hit = at_stop(stop_phase);
    while (!hit && n < budget) begin
      arb_grant = arb_req;
      ack_in = (m_busy && !m_done && m_wait) ? {1'b1, exp_id(m_phase)} : 3'b000;
      step();
      check_model();
      n++;
      hit = at_stop(stop_phase);
    end
    arb_grant = 1'b0;
    ack_in    = 3'b000;
    chk($sformatf("advance_to_%0d", stop_phase), 64'(hit), 64'd1);
  endtask

  task automatic release_completion();
    comq_ready_in = 1'b1;
    step();
    comq_ready_in = 1'b0;
    chk("release_idle", 64'(ready_req_out), 64'd1);
  endtask

  task automatic issue(input logic [RW-1:0] rq);
    req_data  = rq;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("issue_accepted", 64'(arb_req), 64'd1);
  endtask

  typedef struct {
    logic          rv;
    logic          g;
    logic [2:0]    ack;
    logic          cr;
    logic          e_rdy;
    logic          e_arb;
    logic [DW-1:0] e_data;
    logic          e_vld;
    logic [CW-1:0] e_cq;
  } vec_t;

  vec_t tv [11];

  localparam logic [RW-1:0] R1 = {1'b1, 24'h000200, 24'h000100, 24'h000300};
  localparam logic [RW-1:0] R2 = {1'b0, 24'hABCDEF, 24'h123456, 24'h00BEEF};
  localparam logic [RW-1:0] R3 = {1'b1, 24'h111111, 24'h222222, 24'h333333};
  localparam logic [RW-1:0] R4 = {1'b0, 24'h0A0A0A, 24'h050505, 24'h444444};
  localparam logic [RW-1:0] R5 = {1'b1, 24'h00CAFE, 24'h00F00D, 24'h555555};
  localparam logic [RW-1:0] R6 = {1'b0, 24'h777777, 24'h666666, 24'h888888};

  initial begin
    int hs0;
    int n;
    bit quiet;

    tv[0]  = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 25'h0};
    tv[1]  = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0001_0011, 1'b0, 25'h0};
    tv[2]  = '{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 32'h0001_0011, 1'b0, 25'h0};
    tv[3]  = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0002_0011, 1'b0, 25'h0};
    tv[4]  = '{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 32'h0002_0011, 1'b0, 25'h0};
    tv[5]  = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0000_0093, 1'b0, 25'h0};
    tv[6]  = '{1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 32'h0000_0093, 1'b0, 25'h0};
    tv[7]  = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0003_0006, 1'b0, 25'h0};
    tv[8]  = '{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 32'h0003_0006, 1'b0, 25'h0};
    tv[9]  = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 25'h000_0300};
    tv[10] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 25'h0};

    rst = 1'b1; req_valid = 1'b0; req_data = '0; arb_grant = 1'b0;
    ack_in = 3'b000; comq_ready_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    chk("reset_ready", 64'(ready_req_out), 64'd1);
    chk("reset_arb_req", 64'(arb_req), 64'd0);
    chk("reset_data_out", 64'(data_out), 64'd0);
    chk("reset_valid_compq", 64'(valid_compq_out), 64'd0);
    chk("reset_compq_data", 64'(compq_data_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic transaction from the vector table.
    req_data = R1;
    hs0 = hs_cnt;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("t1_ready[%0d]", i), 64'(ready_req_out), 64'(tv[i].e_rdy));
      chk($sformatf("t1_arb[%0d]", i), 64'(arb_req), 64'(tv[i].e_arb));
      chk($sformatf("t1_data[%0d]", i), 64'(data_out), 64'(tv[i].e_data));
      chk($sformatf("t1_valid[%0d]", i), 64'(valid_compq_out), 64'(tv[i].e_vld));
      chk($sformatf("t1_cq[%0d]", i), 64'(compq_data_out), 64'(tv[i].e_cq));
      req_valid = tv[i].rv; arb_grant = tv[i].g; ack_in = tv[i].ack; comq_ready_in = tv[i].cr;
      step();
    end
    req_valid = 1'b0; arb_grant = 1'b0; ack_in = 3'b000; comq_ready_in = 1'b0;
    chk("t1_handshakes", 64'(hs_cnt - hs0), 64'd1);

    // Grant withheld for 20 cycles in RD_REQ: no timeout there.
    issue(R2);
    for (int i = 0; i < 20; i++) begin
      chk("t2_arb_held", 64'(arb_req), 64'd1);
      chk("t2_data_held", 64'(data_out), 64'h1234_5611);
      step();
    end
    check_model();
    advance(-1, 100);
    chk("t2_completion", 64'(compq_data_out), 64'({1'b0, 24'h00BEEF}));
    release_completion();

    // Op ACK withheld: counter runs 0..2^TW-1, i.e. 2^TW WAIT cycles, then COMPLETE.
    issue(R3);
    advance(NUM_SRC, 100);
    n = 0;
    while (!valid_compq_out && n < 64) begin
      chk("t3_op_word_held", 64'(data_out), 64'h0000_0093);
      chk("t3_no_arb", 64'(arb_req), 64'd0);
      step();
      check_model();
      n++;
    end
    chk("t3_tmo_cycles", 64'(n), 64'(2**TW));
    chk("t3_err_completion", 64'(compq_data_out), 64'({1'b1, 24'h333333}));
    release_completion();

    // ACK qualification.
    issue(R4);
    arb_grant = 1'b1; ack_in = {1'b1, MEM};
    step(); check_model();
    chk("t4_grant_cycle_ack_ignored", 64'(data_out), 64'h0505_0511);
    chk("t4_in_wait", 64'(arb_req), 64'd0);
    arb_grant = 1'b0; ack_in = {1'b1, ACC};
    step(); check_model();
    chk("t4_wrong_id_ignored", 64'(data_out), 64'h0505_0511);
    chk("t4_wrong_id_no_arb", 64'(arb_req), 64'd0);
    ack_in = {1'b1, MEM};
    step(); check_model();
    chk("t4_advanced_src1", 64'(data_out), 64'h0A0A_0A11);
    chk("t4_advanced_arb", 64'(arb_req), 64'd1);
    ack_in = {1'b1, MEM};
    step(); check_model();
    chk("t4_req_ack_ignored", 64'(data_out), 64'h0A0A_0A11);
    chk("t4_req_still_arb", 64'(arb_req), 64'd1);
    ack_in = 3'b000;
    advance(-1, 100);
    chk("t4_completion", 64'(compq_data_out), 64'({1'b0, 24'h444444}));

    // Completion back-pressure with the next request already waiting.
    req_data = R5; req_valid = 1'b1; comq_ready_in = 1'b0;
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("t5_valid_held", 64'(valid_compq_out), 64'd1);
      chk("t5_cq_held", 64'(compq_data_out), 64'({1'b0, 24'h444444}));
      chk("t5_not_ready", 64'(ready_req_out), 64'd0);
      step();
    end
    chk("t5_no_dequeue", 64'(hs_cnt - hs0), 64'd0);
    comq_ready_in = 1'b1;
    step();
    comq_ready_in = 1'b0;
    chk("t5_idle_ready", 64'(ready_req_out), 64'd1);
    chk("t5_valid_dropped", 64'(valid_compq_out), 64'd0);
    step();
    req_valid = 1'b0;
    chk("t5_accepted", 64'(hs_cnt - hs0), 64'd1);
    check_model();

    // Reset during OP_WAIT.
    advance(NUM_SRC, 100);
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_arb_dropped", 64'(arb_req), 64'd0);
    chk("t6_valid_low", 64'(valid_compq_out), 64'd0);
    chk("t6_data_cleared", 64'(data_out), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready_after_release", 64'(ready_req_out), 64'd1);
    chk("t6_no_completion", 64'(valid_compq_out), 64'd0);
    issue(R6);
    advance(-1, 100);
    chk("t6_clean_completion", 64'(compq_data_out), 64'({1'b0, 24'h888888}));
    release_completion();

    // Randomized traffic against the model.
    quiet = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int sel;
      if ($urandom_range(0, 39) == 0) quiet = ~quiet;
      req_valid     = ($urandom_range(0, 3) == 0);
      req_data      = RW'({$urandom, $urandom, $urandom});
      arb_grant     = ($urandom_range(0, 9) < 6);
      comq_ready_in = ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 7);
      if (quiet || sel < 3) ack_in = 3'b000;
      else if (sel < 5)     ack_in = {1'b1, MEM};
      else if (sel == 5)    ack_in = {1'b1, ACC};
      else if (sel == 6)    ack_in = {1'b0, 2'($urandom)};
      else                  ack_in = {1'b1, 2'b11};
      step();
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
